// File: rtl/cci_mpf_prim_track_multi_beat.sv
// Multi-beat packet tracker. Keeps an independent beat counter per stream,
// produces a combinational EOP for the beat at the channel head, counts
// completed packets and reports protocol violations as registered one-cycle
// pulses plus a sticky flag.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no packet in flight on the stream, cnt = 0
// ST_ACTIVE | mid-packet, cnt = index of the next expected beat
module cci_mpf_prim_track_multi_beat #(
    parameter int N_STREAMS  = 1,
    parameter int MAX_BEATS  = 4,
    parameter int ADDR_WIDTH = 42,
    parameter int CNT_WIDTH  = 16,
    localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
    localparam int SID_W  = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_en,
    input  logic [SID_W-1:0]      in_stream,
    input  logic                  in_sop,
    input  logic [BEAT_W-1:0]     in_len,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  err_clear,
    output logic                  eop,
    output logic [BEAT_W-1:0]     next_beat_num,
    output logic [N_STREAMS-1:0]  packet_active,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  err_sop,
    output logic                  err_len,
    output logic                  err_addr,
    output logic                  err_sticky
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [BEAT_W:0] MAX_BEATS_W = (BEAT_W + 1)'(MAX_BEATS);

    state_t                  state_q [N_STREAMS];
    state_t                  state_d [N_STREAMS];
    logic [BEAT_W-1:0]       cnt_q   [N_STREAMS];
    logic [BEAT_W-1:0]       cnt_d   [N_STREAMS];
    logic [BEAT_W-1:0]       len_q   [N_STREAMS];
    logic [BEAT_W-1:0]       len_d   [N_STREAMS];
    logic [ADDR_WIDTH-1:0]   addr_q  [N_STREAMS];
    logic [ADDR_WIDTH-1:0]   addr_d  [N_STREAMS];

    logic [CNT_WIDTH-1:0]    pkt_count_q, pkt_count_d;
    logic                    err_sop_q, err_sop_d;
    logic                    err_len_q, err_len_d;
    logic                    err_addr_q, err_addr_d;
    logic                    err_sticky_q, err_sticky_d;

    // View of the stream addressed by the head beat
    logic [N_STREAMS-1:0]    hit;
    state_t                  cur_state;
    logic [BEAT_W-1:0]       cur_cnt;
    logic [BEAT_W-1:0]       cur_len;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_active;

    logic [BEAT_W:0]         len_p1;
    logic                    len_legal;
    logic                    sop_aligned;
    logic                    accept;

    // Next state of the addressed stream, fanned out to the per-stream arrays
    state_t                  sel_state_d;
    logic [BEAT_W-1:0]       sel_cnt_d;
    logic                    sel_latch;

    // Select the state of the stream named by in_stream; an out-of-range ID hits nothing
    always_comb begin : sel_comb
        hit       = '0;
        cur_state = ST_IDLE;
        cur_cnt   = '0;
        cur_len   = '0;
        cur_addr  = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            if (in_stream == SID_W'(i)) begin
                hit[i]    = 1'b1;
                cur_state = state_q[i];
                cur_cnt   = cnt_q[i];
                cur_len   = len_q[i];
                cur_addr  = addr_q[i];
            end
        end
    end

    assign cur_active = (cur_state == ST_ACTIVE);
    assign accept     = in_valid & in_en & (|hit);

    // Length is legal when len+1 is a power of two not above MAX_BEATS.
    // Alignment is judged only for legal lengths, so a bad length does not
    // also raise a spurious address error.
    assign len_p1      = {1'b0, in_len} + (BEAT_W + 1)'(1);
    assign len_legal   = ((len_p1 & (len_p1 - (BEAT_W + 1)'(1))) == '0) &&
                         (len_p1 <= MAX_BEATS_W);
    assign sop_aligned = ((in_addr[BEAT_W-1:0] & in_len) == '0);

    // Next-state logic: per-stream packet FSM, packet counter and error pulses
    always_comb begin : next_comb
        sel_state_d  = cur_state;
        sel_cnt_d    = cur_cnt;
        sel_latch    = 1'b0;
        pkt_count_d  = pkt_count_q;
        err_sop_d    = 1'b0;
        err_len_d    = 1'b0;
        err_addr_d   = 1'b0;

        if (accept) begin
            if (!cur_active || in_sop) begin
                // Start of a packet. A missing SOP on an idle stream and an SOP
                // on an active stream both resync here; the abandoned packet
                // is not counted.
                err_sop_d  = (cur_active == in_sop);
                err_len_d  = !len_legal;
                err_addr_d = len_legal && !sop_aligned;
                sel_latch  = 1'b1;
                if (in_len == '0) begin
                    sel_state_d = ST_IDLE;
                    sel_cnt_d   = '0;
                    pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                end else begin
                    sel_state_d = ST_ACTIVE;
                    sel_cnt_d   = BEAT_W'(1);
                end
            end else begin
                err_len_d  = (in_len != cur_len);
                err_addr_d = (in_addr != cur_addr);
                if (cur_cnt == cur_len) begin
                    sel_state_d = ST_IDLE;
                    sel_cnt_d   = '0;
                    pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
                end else begin
                    sel_cnt_d = cur_cnt + BEAT_W'(1);
                end
            end
        end

        for (int i = 0; i < N_STREAMS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            len_d[i]   = len_q[i];
            addr_d[i]  = addr_q[i];
            if (accept && hit[i]) begin
                state_d[i] = sel_state_d;
                cnt_d[i]   = sel_cnt_d;
                if (sel_latch) begin
                    len_d[i]  = in_len;
                    addr_d[i] = in_addr;
                end
            end
        end

        // A fresh error outranks a simultaneous clear
        if (err_sop_d || err_len_d || err_addr_d) begin
            err_sticky_d = 1'b1;
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            for (int i = 0; i < N_STREAMS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                len_q[i]   <= '0;
                addr_q[i]  <= '0;
            end
            pkt_count_q  <= '0;
            err_sop_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_addr_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_STREAMS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                len_q[i]   <= len_d[i];
                addr_q[i]  <= addr_d[i];
            end
            pkt_count_q  <= pkt_count_d;
            err_sop_q    <= err_sop_d;
            err_len_q    <= err_len_d;
            err_addr_q   <= err_addr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Outputs: combinational EOP / beat number for the head beat, per-stream activity
    always_comb begin : out_comb
        next_beat_num = cur_cnt;
        if (in_valid) begin
            eop = (cur_cnt == (cur_active ? cur_len : in_len));
        end else begin
            eop = 1'b1;
        end
        for (int i = 0; i < N_STREAMS; i++) begin
            packet_active[i] = (state_q[i] == ST_ACTIVE);
        end
    end

    assign pkt_count  = pkt_count_q;
    assign err_sop    = err_sop_q;
    assign err_len    = err_len_q;
    assign err_addr   = err_addr_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_cci_mpf_prim_track_multi_beat.sv
// Directed bench for the multi-beat tracker with two streams and 4-beat packets.
module tb_cci_mpf_prim_track_multi_beat;

    localparam int N_STREAMS  = 2;
    localparam int MAX_BEATS  = 4;
    localparam int ADDR_WIDTH = 42;
    localparam int CNT_WIDTH  = 16;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_en;
    logic [0:0]            in_stream;
    logic                  in_sop;
    logic [1:0]            in_len;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic                  err_clear;
    logic                  eop;
    logic [1:0]            next_beat_num;
    logic [1:0]            packet_active;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic                  err_sop;
    logic                  err_len;
    logic                  err_addr;
    logic                  err_sticky;

    int n_cmp;
    int n_err;

    cci_mpf_prim_track_multi_beat #(
        .N_STREAMS (N_STREAMS),
        .MAX_BEATS (MAX_BEATS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_en        (in_en),
        .in_stream    (in_stream),
        .in_sop       (in_sop),
        .in_len       (in_len),
        .in_addr      (in_addr),
        .err_clear    (err_clear),
        .eop          (eop),
        .next_beat_num(next_beat_num),
        .packet_active(packet_active),
        .pkt_count    (pkt_count),
        .err_sop      (err_sop),
        .err_len      (err_len),
        .err_addr     (err_addr),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        en;
        logic [0:0]  sid;
        logic        sop;
        logic [1:0]  len;
        logic [11:0] addr;
        logic        clr;
        logic        x_eop;
        logic [1:0]  x_nbn;
        logic [1:0]  x_pa;
        logic [15:0] x_cnt;
        logic        x_esop;
        logic        x_elen;
        logic        x_eaddr;
        logic        x_stk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic e, logic [0:0] s, logic sp, logic [1:0] l,
                                logic [11:0] a, logic c, logic xe, logic [1:0] xn,
                                logic [1:0] xpa, logic [15:0] xc, logic xs, logic xl,
                                logic xa, logic xk);
        vec_t r;
        r.valid = v;  r.en = e;  r.sid = s;  r.sop = sp;  r.len = l;  r.addr = a;  r.clr = c;
        r.x_eop = xe; r.x_nbn = xn; r.x_pa = xpa; r.x_cnt = xc;
        r.x_esop = xs; r.x_elen = xl; r.x_eaddr = xa; r.x_stk = xk;
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic e, logic [0:0] s, logic sp, logic [1:0] l,
                         logic [11:0] a, logic c);
        in_valid  = v;
        in_en     = e;
        in_stream = s;
        in_sop    = sp;
        in_len    = l;
        in_addr   = ADDR_WIDTH'(a);
        err_clear = c;
    endtask

    task automatic check_regs(string tag, logic [1:0] pa, logic [15:0] cnt, logic es,
                              logic el, logic ea, logic stk);
        chk({tag, "_pa"},    64'(packet_active), 64'(pa));
        chk({tag, "_cnt"},   64'(pkt_count),     64'(cnt));
        chk({tag, "_esop"},  64'(err_sop),       64'(es));
        chk({tag, "_elen"},  64'(err_len),       64'(el));
        chk({tag, "_eaddr"}, 64'(err_addr),      64'(ea));
        chk({tag, "_stk"},   64'(err_sticky),    64'(stk));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0);

        //              v  e  s  sop len addr    clr | eop nbn | pa  cnt esop elen eaddr stk
        // single 4-beat packet, stream 0
        vecs.push_back(mk(1, 1, 0, 1, 3, 12'h040, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 0, 2, 2'b01, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 1, 3, 2'b00, 1, 0, 0, 0, 0));
        // beat not consumed / no beat: no state change
        vecs.push_back(mk(1, 0, 0, 1, 3, 12'h040, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 3, 12'h040, 0, 1, 0, 2'b00, 1, 0, 0, 0, 0));
        // interleaved streams: s0 len=1, s1 len=3
        vecs.push_back(mk(1, 1, 0, 1, 1, 12'h080, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3, 12'h0C0, 0, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 12'h080, 0, 1, 1, 2'b10, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3, 12'h0C0, 0, 0, 1, 2'b10, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3, 12'h0C0, 0, 0, 2, 2'b10, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 3, 12'h0C0, 0, 1, 3, 2'b00, 3, 0, 0, 0, 0));
        // single-beat packet (len=0): eop on the SOP beat, stays idle
        vecs.push_back(mk(1, 1, 0, 1, 0, 12'h041, 0, 1, 0, 2'b00, 4, 0, 0, 0, 0));
        // SOP on beat 2 of an active packet: restart, old packet not counted
        vecs.push_back(mk(1, 1, 0, 1, 3, 12'h040, 0, 0, 0, 2'b01, 4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 0, 1, 2'b01, 4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 3, 12'h040, 0, 0, 2, 2'b01, 4, 1, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 0, 1, 2'b01, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 0, 2, 2'b01, 4, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h040, 0, 1, 3, 2'b00, 5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'h000, 1, 1, 0, 2'b00, 5, 0, 0, 0, 0));
        // len 3->1 and addr 0x40->0x44 on beat 1 of stream 1
        vecs.push_back(mk(1, 1, 1, 1, 3, 12'h040, 0, 0, 0, 2'b10, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 1, 12'h044, 0, 0, 1, 2'b10, 5, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 3, 12'h040, 0, 0, 2, 2'b10, 5, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 0, 3, 12'h040, 1, 1, 3, 2'b00, 6, 0, 0, 0, 0));
        // illegal len=2 (still tracked as 3 beats), then misaligned SOP with clear
        vecs.push_back(mk(1, 1, 0, 1, 2, 12'h040, 0, 0, 0, 2'b01, 6, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 2, 12'h040, 0, 0, 1, 2'b01, 6, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 2, 12'h040, 0, 1, 2, 2'b00, 7, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 3, 12'h042, 1, 0, 0, 2'b01, 7, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'h000, 1, 1, 1, 2'b01, 7, 0, 0, 0, 0));
        // advance stream 0 to cnt=2 ahead of the async reset
        vecs.push_back(mk(1, 1, 0, 0, 3, 12'h042, 0, 0, 1, 2'b01, 7, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check_regs("rst", 2'b00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_eop", 64'(eop), 64'(1'b1));
        chk("rst_nbn", 64'(next_beat_num), 64'(2'd0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].en, vecs[i].sid, vecs[i].sop, vecs[i].len,
                  vecs[i].addr, vecs[i].clr);
            @(negedge clk);
            chk($sformatf("v%0d_eop", i), 64'(eop), 64'(vecs[i].x_eop));
            chk($sformatf("v%0d_nbn", i), 64'(next_beat_num), 64'(vecs[i].x_nbn));
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].x_pa, vecs[i].x_cnt, vecs[i].x_esop,
                       vecs[i].x_elen, vecs[i].x_eaddr, vecs[i].x_stk);
        end

        // asynchronous reset mid-packet (stream 0 at cnt=2), away from any edge
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 12'h042, 1'b0);
        chk("pre_arst_nbn", 64'(next_beat_num), 64'(2'd2));
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pa",  64'(packet_active), 64'(2'b00));
        chk("arst_cnt", 64'(pkt_count),     64'(16'd0));
        chk("arst_nbn", 64'(next_beat_num), 64'(2'd0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // clean restart after reset
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 12'h040, 1'b0);
        @(negedge clk);
        chk("post_arst_eop", 64'(eop), 64'(1'b0));
        chk("post_arst_nbn", 64'(next_beat_num), 64'(2'd0));
        @(posedge clk);
        #1;
        check_regs("post_arst", 2'b01, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 12'h040, 1'b0);
        @(negedge clk);
        chk("post_arst_b1_nbn", 64'(next_beat_num), 64'(2'd1));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cci_mpf_prim_track_multi_beat.md
Name: cci_mpf_prim_track_multi_beat

Overview:
- Parametrised multi-beat packet tracker that succeeds the single-stream write-beat tracker.
- Tracks up to N_STREAMS interleaved multi-beat packet streams, each with its own beat counter.
- Detects protocol violations and reports them as registered error pulses plus a sticky flag, instead of halting simulation.
- Sits beside MPF channel pipelines (c1Tx writes, or any multi-beat channel) to generate EOP and support packet-boundary logic.

Parameters:
N_STREAMS, 1, number of independently tracked streams
MAX_BEATS, 4, maximum beats per packet; must be a power of two ≥1
ADDR_WIDTH, 42, line-address width
CNT_WIDTH, 16, completed-packet counter width
(derived) BEAT_W = max(1,$clog2(MAX_BEATS)); SID_W = max(1,$clog2(N_STREAMS))

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  beat present at channel head and is a multi-beat request
in_en  in  1  beat consumed this cycle; only meaningful with in_valid
in_stream  in  SID_W  stream ID of beat
in_sop  in  1  SOP marker carried by beat
in_len  in  BEAT_W  encoded length (beats-1)
in_addr  in  ADDR_WIDTH  line address carried by beat
err_clear  in  1  clears err_sticky
eop  out  1  current beat is last of its packet (combinational)
next_beat_num  out  BEAT_W  expected beat number for in_stream (combinational)
packet_active  out  N_STREAMS  per-stream mid-packet flag
pkt_count  out  CNT_WIDTH  completed packets, all streams
err_sop  out  1  pulse: SOP out of phase
err_len  out  1  pulse: illegal length or length change mid-packet
err_addr  out  1  pulse: address misaligned or changed mid-packet
err_sticky  out  1  OR of all errors since last clear/reset

Behaviour:
- Per-stream state: active bit, beat counter cnt[BEAT_W], latched len, latched base addr. States IDLE (active=0, cnt=0) and ACTIVE.
- Reset (async assert, any time, including mid-packet): all streams IDLE, cnt=0, pkt_count=0, all err outputs 0.
- Effective length: eff_len = ACTIVE ? latched len : in_len. next_beat_num = cnt[in_stream]. eop = in_valid ? (cnt[in_stream]==eff_len) : 1.
- Legal length: in_len+1 is a power of two and ≤ MAX_BEATS. Legal SOP beat: addr low log2(in_len+1) bits are zero.
- Accepted beat (in_valid & in_en) on stream s updates state at the next clk edge:
  - IDLE, in_sop=1: latch len and addr. If in_len==0, stay IDLE and increment pkt_count. Otherwise go ACTIVE with cnt=1.
  - IDLE, in_sop=0: flag err_sop, then process as an SOP beat (resync).
  - ACTIVE, in_sop=0: if in_len≠latched len, flag err_len. If in_addr≠latched addr, flag err_addr. Compare cnt against latched len: on equal (eop), go IDLE, cnt=0, pkt_count+1. Otherwise cnt+1.
  - ACTIVE, in_sop=1: flag err_sop, abandon the old packet (no count), restart as a fresh SOP beat.
  - Illegal length or misaligned address on an SOP beat: flag err_len / err_addr. The packet is still tracked using in_len as given.
- Error pulses are registered and high exactly one cycle after the offending beat. Multiple pulses may assert together.
- err_sticky sets on any pulse. err_clear clears it on the next edge. If a new error and err_clear occur in the same cycle, the error wins and sticky=1.
- pkt_count wraps modulo 2^CNT_WIDTH.
- Other streams are unaffected by beats on stream s.
- With no in_en, or in_valid=0, no state changes.
- Latency: eop and next_beat_num are 0-cycle combinational; state and pulses update 1 cycle after acceptance.

Test Plan:
- Reset, then a single 4-beat packet on stream 0 (len=3, addr=0x40, sop on beat 0 only) -> eop=0,0,0,1; next_beat_num 0,1,2,3; packet_active[0]=1 after beats 0–2 and 0 after beat 3; pkt_count=1; no errors.
- N_STREAMS=2: interleave stream0 len=1 and stream1 len=3 beats alternately -> independent counters; pkt_count=2 after both finish; no errors.
- sop=1 on beat 2 of an active len=3 packet -> err_sop pulse one cycle later; stream restarts with cnt=1; old packet not counted.
- Len change 3→1 mid-packet, plus addr 0x40→0x44 on beat 1 -> err_len and err_addr pulse together; err_sticky=1; err_clear with no new error -> sticky=0 next cycle.
- SOP with len=2 (illegal), then SOP len=3 at addr 0x42 (misaligned) -> err_len, then err_addr; err_clear asserted in the same cycle as the second error -> sticky stays 1.
- Assert reset_n=0 asynchronously mid-packet (cnt=2) -> packet_active=0, pkt_count=0 immediately; next packet starts from beat 0 cleanly.
